// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// - Opcode values: instruction bits [6:2].
// - Memory-operation class codes: the upper two bits of memop.
// - decoded_t: one decoded entry. pc and imm are held at the widest XLEN (64).
//   Narrower configurations use only the low XLEN bits of these two fields.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [4:0] {
    OPC_LOAD      = 5'b00000,
    OPC_MISC_MEM  = 5'b00011,
    OPC_OP_IMM    = 5'b00100,
    OPC_AUIPC     = 5'b00101,
    OPC_OP_IMM_32 = 5'b00110,
    OPC_STORE     = 5'b01000,
    OPC_OP        = 5'b01100,
    OPC_LUI       = 5'b01101,
    OPC_OP_32     = 5'b01110,
    OPC_BRANCH    = 5'b11000,
    OPC_JALR      = 5'b11001,
    OPC_JAL       = 5'b11011,
    OPC_SYSTEM    = 5'b11100
  } opcode_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_MISC  = 2'b11
  } mem_class_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                rwEn;
    logic [14:0]         func;
    logic [XLEN_MAX-1:0] imm;
    logic [4:0]          memop;
    logic [6:0]          opcode;
    logic                csrEn;
    logic                csrReadEn;
    logic                illegal;
  } decoded_t;

  // ALU-style function field: funct7 and funct3 side by side.
  function automatic logic [14:0] alu_func(input logic [31:0] insn);
    return {5'h0, insn[31:25], insn[14:12]};
  endfunction

endpackage

// File: rtl/decode_skid.sv
// Two-entry valid/ready buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds valid and payload until then, and the payload
// shown on out_data stays unchanged while out_valid is high and out_ready low.
// Ports:
//   clk, reset_n (sync, active-low), flush (drop everything held)
//   in_valid/in_ready/in_data   : upstream side, in_ready is a register
//   out_valid/out_ready/out_data: downstream side, out_data is the oldest entry
module decode_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic [W-1:0] e0;  // head, presented on out_data
  logic [W-1:0] e1;
  logic         ready_q;
  logic         accept;
  logic         pop;

  assign accept    = in_valid & ready_q;
  assign pop       = (count != 2'd0) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = e0;

  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // ready_q is derived from the next count, so it never depends on
  // out_ready within the same cycle. ready_q==1 implies count<2, hence an
  // accept never coincides with a full buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= 2'd0;
      ready_q <= 1'b0;
      e0      <= '0;
      e1      <= '0;
    end else if (flush) begin
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
      if (pop) begin
        if (count == 2'd2)  e0 <= e1;
        else if (accept)    e0 <= in_data;
      end else if (accept) begin
        if (count == 2'd0)  e0 <= in_data;
        else                e1 <= in_data;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage between fetch and register-read/execute.
// Decodes a 32-bit RISC-V word combinationally and registers the result in a
// two-entry skid buffer, giving one cycle of latency.
// Ports:
//   clk, reset_n (sync, active-low), flush
//   in_valid/in_ready, in_data (instruction), in_pc
//   out_valid/out_ready and the decoded fields out_pc, out_rd, out_rs1,
//   out_rs2, out_rwEn, out_func, out_imm, out_memop, out_opcode, out_csrEn,
//   out_csrReadEn, out_illegal
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rwEn,
  output logic [14:0]     out_func,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_memop,
  output logic [6:0]      out_opcode,
  output logic            out_csrEn,
  output logic            out_csrReadEn,
  output logic            out_illegal
);

  decoded_t dec;
  decoded_t q;
  opcode_e  op;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        writer;
  logic        bad;

  assign op = opcode_e'(in_data[6:2]);
  assign f3 = in_data[14:12];

  assign imm_i = {{52{in_data[31]}}, in_data[31:20]};
  assign imm_s = {{52{in_data[31]}}, in_data[31:25], in_data[11:7]};
  assign imm_b = {{52{in_data[31]}}, in_data[7], in_data[30:25], in_data[11:8], 1'b0};
  assign imm_j = {{44{in_data[31]}}, in_data[19:12], in_data[20], in_data[30:21], 1'b0};
  assign imm_u = {{32{in_data[31]}}, in_data[31:12], 12'h000};

  always_comb begin
    dec           = '0;
    writer        = 1'b0;
    bad           = 1'b0;
    dec.pc        = 64'(in_pc);
    dec.rd        = in_data[11:7];
    dec.rs1       = in_data[19:15];
    dec.rs2       = in_data[24:20];
    dec.opcode    = in_data[6:0];
    case (op)
      OPC_LOAD: begin
        dec.imm   = imm_i;
        dec.memop = {MEM_LOAD, f3};
        writer    = 1'b1;
        bad       = (f3 == 3'b111) || ((f3 == 3'b011) && (XLEN == 32));
      end
      OPC_MISC_MEM: begin
        dec.imm   = imm_i;
        dec.func  = {in_data[31:20], f3};
        dec.memop = {MEM_MISC, 3'b000};
      end
      OPC_OP_IMM: begin
        dec.imm  = imm_i;
        dec.func = alu_func(in_data);
        writer   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u;
        writer  = 1'b1;
      end
      OPC_OP_IMM_32: begin
        dec.imm  = imm_i;
        dec.func = alu_func(in_data);
        writer   = 1'b1;
        bad      = !RV64_OPS;
      end
      OPC_STORE: begin
        dec.imm   = imm_s;
        dec.memop = {MEM_STORE, f3};
        bad       = f3[2];
      end
      OPC_OP: begin
        dec.func = alu_func(in_data);
        writer   = 1'b1;
      end
      OPC_LUI: begin
        dec.imm = imm_u;
        writer  = 1'b1;
      end
      OPC_OP_32: begin
        dec.func = alu_func(in_data);
        writer   = 1'b1;
        bad      = !RV64_OPS;
      end
      OPC_BRANCH: begin
        dec.imm  = imm_b;
        dec.func = {12'h000, f3};
      end
      OPC_JALR: begin
        dec.imm = imm_i;
        writer  = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j;
        writer  = 1'b1;
      end
      OPC_SYSTEM: begin
        dec.imm       = imm_i;
        dec.func      = {in_data[31:20], f3};
        dec.csrEn     = (f3[1:0] != 2'b00);
        dec.csrReadEn = (f3[1:0] != 2'b00) && (in_data[11:7] != 5'd0);
      end
      default: bad = 1'b1;
    endcase

    if (in_data[1:0] != 2'b11) bad = 1'b1;

    // Writes to x0 are dropped here so later stages never see them.
    dec.rwEn    = writer && (in_data[11:7] != 5'd0) && !bad;
    dec.illegal = bad;
    if (bad) begin
      dec.memop     = 5'd0;
      dec.csrEn     = 1'b0;
      dec.csrReadEn = 1'b0;
    end
  end

  decode_skid #(
    .W($bits(decoded_t))
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (q)
  );

  assign out_pc        = q.pc[XLEN-1:0];
  assign out_rd        = q.rd;
  assign out_rs1       = q.rs1;
  assign out_rs2       = q.rs2;
  assign out_rwEn      = q.rwEn;
  assign out_func      = q.func;
  assign out_imm       = q.imm[XLEN-1:0];
  assign out_memop     = q.memop;
  assign out_opcode    = q.opcode;
  assign out_csrEn     = q.csrEn;
  assign out_csrReadEn = q.csrReadEn;
  assign out_illegal   = q.illegal;

  // Upper halves of pc/imm carry nothing in a 32-bit configuration.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{q.pc[XLEN_MAX-1:XLEN], q.imm[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 64-bit instance (RV64 ops enabled) and a 32-bit
// instance (RV64 ops disabled) share one input stream and one out_ready.
module tb_decode_stage;

  localparam int EW = 174;
  localparam int CW = 192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [63:0] in_pc;

  logic        r64, v64, o64_rwEn, o64_csrEn, o64_csrReadEn, o64_illegal;
  logic [63:0] o64_pc, o64_imm;
  logic [4:0]  o64_rd, o64_rs1, o64_rs2, o64_memop;
  logic [14:0] o64_func;
  logic [6:0]  o64_opcode;

  logic        r32, v32, o32_rwEn, o32_csrEn, o32_csrReadEn, o32_illegal;
  logic [31:0] o32_pc, o32_imm;
  logic [4:0]  o32_rd, o32_rs1, o32_rs2, o32_memop;
  logic [14:0] o32_func;
  logic [6:0]  o32_opcode;

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_data(in_data), .in_pc(in_pc),
    .out_valid(v64), .out_ready(out_ready), .out_pc(o64_pc),
    .out_rd(o64_rd), .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_rwEn(o64_rwEn),
    .out_func(o64_func), .out_imm(o64_imm), .out_memop(o64_memop),
    .out_opcode(o64_opcode), .out_csrEn(o64_csrEn), .out_csrReadEn(o64_csrReadEn),
    .out_illegal(o64_illegal)
  );

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_data(in_data), .in_pc(in_pc[31:0]),
    .out_valid(v32), .out_ready(out_ready), .out_pc(o32_pc),
    .out_rd(o32_rd), .out_rs1(o32_rs1), .out_rs2(o32_rs2), .out_rwEn(o32_rwEn),
    .out_func(o32_func), .out_imm(o32_imm), .out_memop(o32_memop),
    .out_opcode(o32_opcode), .out_csrEn(o32_csrEn), .out_csrReadEn(o32_csrReadEn),
    .out_illegal(o32_illegal)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp64_q[$];
  logic [EW-1:0] exp32_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_out64  = 0;
  int n_out32  = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] got64();
    return {o64_pc, o64_rd, o64_rs1, o64_rs2, o64_rwEn, o64_func, o64_imm,
            o64_memop, o64_opcode, o64_csrEn, o64_csrReadEn, o64_illegal};
  endfunction

  function automatic logic [EW-1:0] got32();
    return {32'h0, o32_pc, o32_rd, o32_rs1, o32_rs2, o32_rwEn, o32_func,
            {{32{o32_imm[31]}}, o32_imm}, o32_memop, o32_opcode,
            o32_csrEn, o32_csrReadEn, o32_illegal};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [31:0] w, input logic [63:0] pc,
                                          input int xlen);
    longint s, u, imm;
    string  kind;
    logic [2:0]  f3;
    logic [4:0]  rd, memop;
    logic [14:0] func;
    logic [63:0] pcx;
    bit bad, rw, csr, csrr;
    s  = longint'($signed(w));
    u  = longint'({32'h0, w});
    f3 = w[14:12];
    rd = w[11:7];
    case (w[6:2])
      5'b00000: kind = "LOAD";
      5'b00011: kind = "MISC";
      5'b00100: kind = "OPIMM";
      5'b00101: kind = "AUIPC";
      5'b00110: kind = "OPIMM32";
      5'b01000: kind = "STORE";
      5'b01100: kind = "OP";
      5'b01101: kind = "LUI";
      5'b01110: kind = "OP32";
      5'b11000: kind = "BRANCH";
      5'b11001: kind = "JALR";
      5'b11011: kind = "JAL";
      5'b11100: kind = "SYSTEM";
      default:  kind = "NONE";
    endcase
    imm = 0;
    if (kind == "LOAD" || kind == "OPIMM" || kind == "OPIMM32" || kind == "JALR" ||
        kind == "SYSTEM" || kind == "MISC")
      imm = s >>> 20;
    else if (kind == "STORE")
      imm = ((s >>> 25) << 5) | ((u >> 7) & 31);
    else if (kind == "BRANCH")
      imm = ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) |
            (((u >> 8) & 15) << 1);
    else if (kind == "JAL")
      imm = ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) |
            (((u >> 21) & 1023) << 1);
    else if (kind == "LUI" || kind == "AUIPC")
      imm = (s >>> 12) << 12;
    func = 15'd0;
    if (kind == "OP" || kind == "OPIMM" || kind == "OP32" || kind == "OPIMM32")
      func = 15'(((u >> 25) << 3) | longint'(f3));
    else if (kind == "BRANCH")
      func = 15'(f3);
    else if (kind == "SYSTEM" || kind == "MISC")
      func = 15'(((u >> 20) << 3) | longint'(f3));
    bad = (w[1:0] != 2'b11) || (kind == "NONE") ||
          ((kind == "OP32" || kind == "OPIMM32") && xlen == 32) ||
          (kind == "LOAD" && (f3 == 3'd7 || (f3 == 3'd3 && xlen == 32))) ||
          (kind == "STORE" && f3 >= 3'd4);
    rw = !bad && rd != 0 &&
         (kind == "LOAD" || kind == "OPIMM" || kind == "AUIPC" || kind == "OP" ||
          kind == "LUI" || kind == "JALR" || kind == "JAL" || kind == "OP32" ||
          kind == "OPIMM32");
    csr  = !bad && kind == "SYSTEM" && (f3 % 4) != 0;
    csrr = csr && rd != 0;
    memop = 5'd0;
    if (!bad && kind == "LOAD")  memop = {2'b01, f3};
    if (!bad && kind == "STORE") memop = {2'b10, f3};
    if (!bad && kind == "MISC")  memop = 5'b11000;
    pcx = (xlen == 32) ? (pc & 64'hFFFF_FFFF) : pc;
    return {pcx, rd, w[19:15], w[24:20], rw, func, 64'(imm), memop, w[6:0], csr, csrr, bad};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [31:0] w, input logic [63:0] pc, input int max_cyc,
                       output bit acc);
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    in_pc    = pc;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      if (r64) begin
        acc = 1'b1;
        exp64_q.push_back(model(w, pc, 64));
        exp32_q.push_back(model(w, pc, 32));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic [63:0] pc);
    bit acc;
    offer(w, pc, 50, acc);
    chk("send accepted", acc, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (v64 || v32); i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("drained", {v64, v32}, 2'b00);
  endtask

  // ---------------- monitor ----------------
  bit            hold64 = 1'b0, hold32 = 1'b0;
  logic [EW-1:0] held64, held32;

  always @(negedge clk) begin
    if (reset_n && !flush) begin
      if (hold64) chk("d64 held stable", {v64, got64()}, {1'b1, held64});
      if (hold32) chk("d32 held stable", {v32, got32()}, {1'b1, held32});
      if (v64 && out_ready) begin
        n_out64++;
        chk("d64 output expected", exp64_q.size() != 0, 1'b1);
        if (exp64_q.size() != 0) chk("d64 entry", got64(), exp64_q.pop_front());
      end
      if (v32 && out_ready) begin
        n_out32++;
        chk("d32 output expected", exp32_q.size() != 0, 1'b1);
        if (exp32_q.size() != 0) chk("d32 entry", got32(), exp32_q.pop_front());
      end
      hold64 = v64 && !out_ready;
      hold32 = v32 && !out_ready;
      held64 = got64();
      held32 = got32();
    end else begin
      hold64 = 1'b0;
      hold32 = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int base64, base32;
    logic [31:0] r, w;
    logic [4:0] ops[13];
    ops = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b01100,
            5'b01101, 5'b01110, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {v64, v32}, 2'b00);
    chk("reset in_ready", {r64, r32}, 2'b00);
    chk("reset d64 fields", got64(), '0);
    chk("reset d32 fields", got32(), '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after release", {r64, r32}, 2'b11);

    // addi x1,x0,-1
    send(32'hFFF0_0093, 64'h1000);
    chk("addi latency", {v64, v32}, 2'b11);
    chk("addi imm64", o64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi imm32", o32_imm, 32'hFFFF_FFFF);
    chk("addi rd/func/rwEn/memop", {o64_rd, o64_func, o64_rwEn, o64_memop},
        {5'd1, 15'h03F8, 1'b1, 5'd0});
    drain();
    // sw x2,8(x1)
    send(32'h0020_A423, 64'h1004);
    chk("sw fields", {o64_memop, o64_imm, o64_rs1, o64_rs2, o64_rwEn},
        {5'b10010, 64'd8, 5'd1, 5'd2, 1'b0});
    drain();
    // jal x1,-4
    send(32'hFFDF_F0EF, 64'h1008);
    chk("jal fields", {o64_imm, o64_rwEn, o64_rd}, {64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 5'd1});
    drain();
    // csrrw x0,0x300,x1
    send(32'h3000_9073, 64'h100C);
    chk("csrrw fields", {o64_csrEn, o64_csrReadEn, o64_func, o64_rwEn},
        {1'b1, 1'b0, 12'h300, 3'b001, 1'b0});
    drain();
    send(32'h0000_0013, 64'h1010);
    chk("addi x0 rwEn", {o64_rwEn, o32_rwEn}, 2'b00);
    drain();
    // illegal words
    send(32'h0000_0000, 64'h2000);
    chk("zero word d64", {o64_illegal, o64_rwEn, o64_memop, o64_pc},
        {1'b1, 1'b0, 5'd0, 64'h2000});
    drain();
    send(32'h0000_003B, 64'h2004);
    chk("op32 on xlen32", {o32_illegal, o32_rwEn, o32_memop, o32_pc},
        {1'b1, 1'b0, 5'd0, 32'h2004});
    chk("op32 on xlen64", o64_illegal, 1'b0);
    drain();
    // ld x1,0(x1): legal only at 64 bits
    send(32'h0000_B083, 64'h2008);
    chk("ld legality", {o64_illegal, o64_rwEn, o32_illegal, o32_rwEn}, 4'b0110);
    drain();

    // backpressure: three words offered, two fit
    base64 = n_out64; base32 = n_out32;
    send(32'h0010_0093, 64'h3000);
    send(32'h0020_0113, 64'h3004);
    offer(32'h0030_0193, 64'h3008, 4, acc);
    chk("full rejects third", acc, 1'b0);
    chk("full in_ready", {r64, r32}, 2'b00);
    chk("full head is first", o64_pc, 64'h3000);
    out_ready = 1'b1;
    offer(32'h0030_0193, 64'h3008, 50, acc);
    chk("third accepted later", acc, 1'b1);
    drain();
    chk("three emerged", {n_out64 - base64, n_out32 - base32}, {32'd3, 32'd3});

    // flush with a full buffer and a word offered
    send(32'h0040_0213, 64'h4000);
    send(32'h0050_0293, 64'h4004);
    in_valid = 1'b1; in_data = 32'h0060_0313; in_pc = 64'h4008;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp64_q.delete(); exp32_q.delete();
    chk("flush full state", {v64, v32, r64, r32}, 4'b0011);
    // flush while a word is being accepted into a one-entry buffer
    send(32'h0070_0393, 64'h4010);
    in_valid = 1'b1; in_data = 32'h0080_0413; in_pc = 64'h4014;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp64_q.delete(); exp32_q.delete();
    chk("flush accept state", {v64, v32, r64, r32}, 4'b0011);
    base64 = n_out64; base32 = n_out32;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("flushed words absent", {n_out64 - base64, n_out32 - base32}, 64'd0);

    // reset mid-stream
    send(32'h0090_0493, 64'h5000);
    send(32'h00A0_0513, 64'h5004);
    in_valid = 1'b1; in_data = 32'h00B0_0593;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset state", {v64, v32, r64, r32}, 4'b0000);
    chk("midreset d64 fields", got64(), '0);
    chk("midreset d32 fields", got32(), '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp64_q.delete(); exp32_q.delete();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset release", {v64, v32, r64, r32}, 4'b0011);

    // randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      r = $urandom();
      case ($urandom_range(0, 9))
        0:       w = r;
        1:       w = {r[31:2], 2'b01};
        default: w = {r[31:7], ops[$urandom_range(0, 12)], 2'b11};
      endcase
      send(w, {$urandom(), $urandom()});
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp64_q.size() != 0 || exp32_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    chk("queues empty", {exp64_q.size(), exp32_q.size()}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
